// File: rtl/grid_step_mover_if.sv
// Bundle of per-object control and position signals between the game logic
// (master) and one grid_step_mover instance (slave).
interface grid_step_mover_if;
  logic               startOfFrame;
  logic               respawn;
  logic               keyUp;
  logic               keyDown;
  logic               keyLeft;
  logic               keyRight;
  logic               blkUp;
  logic               blkDown;
  logic               blkLeft;
  logic               blkRight;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               moving;
  logic        [1:0]  facing;
  logic               stepDone;

  modport master (
    output startOfFrame, respawn,
    output keyUp, keyDown, keyLeft, keyRight,
    output blkUp, blkDown, blkLeft, blkRight,
    input  topLeftX, topLeftY, moving, facing, stepDone
  );

  modport slave (
    input  startOfFrame, respawn,
    input  keyUp, keyDown, keyLeft, keyRight,
    input  blkUp, blkDown, blkLeft, blkRight,
    output topLeftX, topLeftY, moving, facing, stepDone
  );
endinterface

// File: rtl/grid_step_mover.sv
// Tile-grid object mover: a key request starts a one-tile step that is then
// advanced SPEED px per frame until the object rests tile-aligned again.
module grid_step_mover #(
  parameter int TILE_SIZE = 32,
  parameter int SPEED     = 2,
  parameter int INIT_X    = 32,
  parameter int INIT_Y    = 32,
  parameter int MIN_X     = 32,
  parameter int MIN_Y     = 32,
  parameter int MAX_X     = 576,
  parameter int MAX_Y     = 416
) (
  input  logic              clk,
  input  logic              resetN,
  grid_step_mover_if.slave  bus
);

  typedef enum logic {
    IDLE,
    MOVING
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Counter needs to hold TILE_SIZE itself, hence one extra bit.
  localparam int CW = $clog2(TILE_SIZE) + 1;

  localparam logic [CW-1:0]      SPEED_C = CW'(SPEED);
  localparam logic [CW-1:0]      TILE_C  = CW'(TILE_SIZE);
  localparam logic signed [10:0] SPEED_P = 11'(SPEED);
  localparam logic signed [10:0] INIT_XP = 11'(INIT_X);
  localparam logic signed [10:0] INIT_YP = 11'(INIT_Y);

  // Target arithmetic is done one bit wider so the bound check itself can
  // never wrap.
  localparam logic signed [11:0] TILE_W  = 12'(TILE_SIZE);
  localparam logic signed [11:0] MIN_XW  = 12'(MIN_X);
  localparam logic signed [11:0] MIN_YW  = 12'(MIN_Y);
  localparam logic signed [11:0] MAX_XW  = 12'(MAX_X);
  localparam logic signed [11:0] MAX_YW  = 12'(MAX_Y);

  state_t             state;
  dir_t               step_dir;
  dir_t               facing_r;
  logic [CW-1:0]      counter;
  logic signed [10:0] pos_x;
  logic signed [10:0] pos_y;
  logic               moving_r;
  logic               step_done_r;

  logic               sel_valid;
  dir_t               sel_dir;
  logic               sel_blk;
  logic signed [11:0] tgt_x;
  logic signed [11:0] tgt_y;
  logic               tgt_ok;
  logic               last_inc;

  // Pick the highest-priority key, its blocked flag, and check the tile it
  // would move to against the legal resting area.
  always_comb begin
    sel_valid = 1'b1;
    sel_dir   = DIR_UP;
    sel_blk   = bus.blkUp;
    tgt_x     = {pos_x[10], pos_x};
    tgt_y     = {pos_y[10], pos_y};
    if (bus.keyUp) begin
      sel_dir = DIR_UP;
      sel_blk = bus.blkUp;
    end else if (bus.keyDown) begin
      sel_dir = DIR_DOWN;
      sel_blk = bus.blkDown;
    end else if (bus.keyLeft) begin
      sel_dir = DIR_LEFT;
      sel_blk = bus.blkLeft;
    end else if (bus.keyRight) begin
      sel_dir = DIR_RIGHT;
      sel_blk = bus.blkRight;
    end else begin
      sel_valid = 1'b0;
    end
    case (sel_dir)
      DIR_UP:    tgt_y = {pos_y[10], pos_y} - TILE_W;
      DIR_DOWN:  tgt_y = {pos_y[10], pos_y} + TILE_W;
      DIR_LEFT:  tgt_x = {pos_x[10], pos_x} - TILE_W;
      default:   tgt_x = {pos_x[10], pos_x} + TILE_W;
    endcase
    tgt_ok = (tgt_x >= MIN_XW) && (tgt_x <= MAX_XW) &&
             (tgt_y >= MIN_YW) && (tgt_y <= MAX_YW) && !sel_blk;
    last_inc = ((counter + SPEED_C) == TILE_C);
  end

  // Step FSM: respawn beats everything, otherwise act only on frame pulses.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      step_dir    <= DIR_DOWN;
      facing_r    <= DIR_DOWN;
      counter     <= '0;
      pos_x       <= INIT_XP;
      pos_y       <= INIT_YP;
      moving_r    <= 1'b0;
      step_done_r <= 1'b0;
    end else begin
      step_done_r <= 1'b0;
      if (bus.respawn) begin
        state    <= IDLE;
        counter  <= '0;
        pos_x    <= INIT_XP;
        pos_y    <= INIT_YP;
        moving_r <= 1'b0;
      end else if (bus.startOfFrame) begin
        case (state)
          IDLE: begin
            if (sel_valid) begin
              facing_r <= sel_dir;
              if (tgt_ok) begin
                state    <= MOVING;
                step_dir <= sel_dir;
                counter  <= '0;
                moving_r <= 1'b1;
              end
            end
          end
          MOVING: begin
            case (step_dir)
              DIR_UP:    pos_y <= pos_y - SPEED_P;
              DIR_DOWN:  pos_y <= pos_y + SPEED_P;
              DIR_LEFT:  pos_x <= pos_x - SPEED_P;
              default:   pos_x <= pos_x + SPEED_P;
            endcase
            if (last_inc) begin
              state       <= IDLE;
              counter     <= '0;
              moving_r    <= 1'b0;
              step_done_r <= 1'b1;
            end else begin
              counter <= counter + SPEED_C;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.topLeftX = pos_x;
  assign bus.topLeftY = pos_y;
  assign bus.moving   = moving_r;
  assign bus.facing   = facing_r;
  assign bus.stepDone = step_done_r;

endmodule

// File: tb/tb_grid_step_mover.sv
// Directed bench for grid_step_mover: walks the object around the grid,
// probing priority, bounds, blocking, mid-step input changes, respawn and
// asynchronous reset.
module tb_grid_step_mover;

  logic clk;
  logic resetN;
  int   errors;
  int   checks;
  int   done_count;

  grid_step_mover_if bus();

  grid_step_mover dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count landing pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.stepDone === 1'b1) done_count++;
  end

  task automatic check(input string tag, input logic signed [31:0] observed,
                       input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One frame pulse; returns #1 after the edge that consumed it.
  task automatic frame();
    @(posedge clk);
    #1 bus.startOfFrame = 1'b1;
    @(posedge clk);
    #1 bus.startOfFrame = 1'b0;
  endtask

  // Start frame plus the 16 moving frames of a full step.
  task automatic full_step();
    frame();
    repeat (16) frame();
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check({tag, " X"}, 32'(bus.topLeftX), ex);
    check({tag, " Y"}, 32'(bus.topLeftY), ey);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    done_count = 0;
    resetN = 1'b0;
    bus.startOfFrame = 0; bus.respawn = 0;
    bus.keyUp = 0; bus.keyDown = 0; bus.keyLeft = 0; bus.keyRight = 0;
    bus.blkUp = 0; bus.blkDown = 0; bus.blkLeft = 0; bus.blkRight = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_pos("reset", 32, 32);
    check("reset moving", 32'(bus.moving), 0);
    check("reset facing", 32'(bus.facing), 1);
    check("reset stepDone", 32'(bus.stepDone), 0);
    resetN = 1'b1;
    repeat (3) frame();
    check_pos("idle", 32, 32);
    check("idle moving", 32'(bus.moving), 0);
    check("idle no stepDone", done_count, 0);

    // Right step, 2 px per frame
    bus.keyRight = 1;
    frame();
    check("right start moving", 32'(bus.moving), 1);
    check("right start X", 32'(bus.topLeftX), 32);
    check("right facing", 32'(bus.facing), 3);
    for (int i = 1; i <= 16; i++) begin
      frame();
      check("right X", 32'(bus.topLeftX), 32 + 2 * i);
      check("right moving", 32'(bus.moving), (i < 16) ? 1 : 0);
      check("right stepDone", 32'(bus.stepDone), (i == 16) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    check("stepDone one clk", 32'(bus.stepDone), 0);
    check("done count 1", done_count, 1);
    frame();
    check("second step starts", 32'(bus.moving), 1);
    check("second step X", 32'(bus.topLeftX), 64);
    repeat (16) frame();
    bus.keyRight = 0;
    check_pos("after two steps", 96, 32);

    // Back left to X=64
    bus.keyLeft = 1;
    full_step();
    bus.keyLeft = 0;
    check_pos("left step", 64, 32);

    // Down step completes even after key release and blocking mid-step
    bus.keyDown = 1;
    frame();
    check("down start moving", 32'(bus.moving), 1);
    check("down facing", 32'(bus.facing), 1);
    bus.keyDown = 0;
    repeat (3) frame();
    check("down mid Y", 32'(bus.topLeftY), 38);
    bus.blkDown = 1;
    repeat (13) frame();
    check_pos("down landed", 64, 64);
    check("down stepDone", 32'(bus.stepDone), 1);
    check("down moving", 32'(bus.moving), 0);
    bus.blkDown = 0;

    // Up beats left
    bus.keyUp = 1; bus.keyLeft = 1;
    frame();
    check("prio facing", 32'(bus.facing), 0);
    check("prio moving", 32'(bus.moving), 1);
    repeat (16) frame();
    bus.keyUp = 0; bus.keyLeft = 0;
    check_pos("prio landed", 64, 32);

    // Blocked tile
    bus.blkRight = 1; bus.keyRight = 1;
    frame();
    check("blocked moving", 32'(bus.moving), 0);
    check("blocked facing", 32'(bus.facing), 3);
    check_pos("blocked", 64, 32);
    bus.keyRight = 0; bus.blkRight = 0;

    // Lower bounds
    bus.keyLeft = 1;
    full_step();
    check_pos("to min X", 32, 32);
    frame();
    check("min X moving", 32'(bus.moving), 0);
    check("min X facing", 32'(bus.facing), 2);
    check_pos("min X", 32, 32);
    bus.keyLeft = 0;
    bus.keyUp = 1;
    frame();
    check("min Y moving", 32'(bus.moving), 0);
    check("min Y facing", 32'(bus.facing), 0);
    check_pos("min Y", 32, 32);
    bus.keyUp = 0;

    // Upper Y bound: 12 steps down reach 416, the next is refused
    bus.keyDown = 1;
    repeat (12) full_step();
    check_pos("to max Y", 32, 416);
    frame();
    check("max Y moving", 32'(bus.moving), 0);
    check("max Y facing", 32'(bus.facing), 1);
    check_pos("max Y", 32, 416);
    bus.keyDown = 0;
    check("done count total", done_count, 18);

    // Respawn mid-step, coinciding with a frame pulse
    bus.keyRight = 1;
    frame();
    bus.keyRight = 0;
    repeat (5) frame();
    check("pre-respawn X", 32'(bus.topLeftX), 42);
    check("pre-respawn moving", 32'(bus.moving), 1);
    @(posedge clk);
    #1 bus.respawn = 1; bus.startOfFrame = 1;
    @(posedge clk);
    #1 bus.respawn = 0; bus.startOfFrame = 0;
    check_pos("respawn", 32, 32);
    check("respawn moving", 32'(bus.moving), 0);
    check("respawn facing kept", 32'(bus.facing), 3);
    check("respawn stepDone", 32'(bus.stepDone), 0);
    frame();
    check("post-respawn idle", 32'(bus.moving), 0);
    check_pos("post-respawn", 32, 32);

    // Asynchronous reset mid-step
    bus.keyDown = 1;
    frame();
    bus.keyDown = 0;
    repeat (3) frame();
    check("pre-reset Y", 32'(bus.topLeftY), 38);
    #2 resetN = 1'b0;
    #1;
    check_pos("async reset", 32, 32);
    check("async reset moving", 32'(bus.moving), 0);
    check("async reset facing", 32'(bus.facing), 1);
    @(posedge clk);
    #1 resetN = 1'b1;
    frame();
    check_pos("after reset", 32, 32);
    check("after reset moving", 32'(bus.moving), 0);
    check("final done count", done_count, 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
